// File: rtl/sa_pkg.sv
// Shared systolic-array constants and small helpers.
// The output collector takes its default sizes from here, as do the other array blocks.
package sa_pkg;

    localparam int SA_DATAWIDTH  = 8;
    localparam int SA_ACC_W      = 4 * SA_DATAWIDTH;
    localparam int SA_N_ROWS     = 4;
    localparam int SA_N_COLS     = 4;
    localparam int SA_OUT_DEPTH  = 4;

    // Classification of one slice of deskewed column valids
    typedef enum logic [1:0] {
        ALIGN_IDLE = 2'd0,   // no column carries data
        ALIGN_PUSH = 2'd1,   // every column carries data: a complete row vector
        ALIGN_SKEW = 2'd2    // some, but not all, columns carry data
    } align_e;

    function automatic align_e align_classify(input logic all_valid, input logic any_valid);
        if (all_valid) begin
            return ALIGN_PUSH;
        end else if (any_valid) begin
            return ALIGN_SKEW;
        end
        return ALIGN_IDLE;
    endfunction

endpackage

// File: rtl/sa_output_collector_if.sv
// Bus bundle between the systolic array bottom row, the output collector and its consumer.
// master = collector side, slave = the environment around it.
interface sa_output_collector_if
    import sa_pkg::*;
#(
    parameter int N_COLS = SA_N_COLS,
    parameter int ACC_W  = SA_ACC_W
);

    logic [N_COLS-1:0]       col_valid;
    logic [N_COLS*ACC_W-1:0] col_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [N_COLS*ACC_W-1:0] out_data;
    logic                    almost_full;
    logic                    overflow;
    logic                    skew_err;

    modport master (
        input  col_valid,
        input  col_data,
        input  out_ready,
        output out_valid,
        output out_data,
        output almost_full,
        output overflow,
        output skew_err
    );

    modport slave (
        output col_valid,
        output col_data,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  almost_full,
        input  overflow,
        input  skew_err
    );

endinterface

// File: rtl/sa_sync_fifo.sv
// Small synchronous FIFO with show-ahead read and an occupancy count.
// A write while full is accepted only when a read frees a slot in the same cycle;
// otherwise it is refused and flagged on drop for one cycle.
module sa_sync_fifo
    import sa_pkg::*;
#(
    parameter int WIDTH = SA_N_COLS * SA_ACC_W,
    parameter int DEPTH = SA_OUT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    logic full;
    logic empty;
    logic do_push;
    logic do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);
    assign drop    = wr_en && full && !do_pop;

    // Storage is small and flop-based so the head word reads back as zero after reset
    assign rd_data  = mem_reg[rd_ptr_reg];
    assign rd_valid = !empty;
    assign count    = count_reg;

    // Pointer, count and storage update; pointers wrap naturally on the power-of-two depth
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= wr_data;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/sa_output_collector.sv
// Systolic-array output collector: removes the diagonal skew of the bottom-row
// outputs, buffers complete row vectors and hands them out over valid/ready.
// Column j arrives j cycles after column 0, so it is delayed N_COLS-1-j cycles
// and all columns line up on the cycle column N_COLS-1 arrives.
module sa_output_collector
    import sa_pkg::*;
#(
    parameter int DATAWIDTH = SA_DATAWIDTH,
    parameter int N_COLS    = SA_N_COLS,
    parameter int DEPTH     = SA_OUT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    sa_output_collector_if.master  bus
);

    localparam int ACC_W = 4 * DATAWIDTH;
    localparam int VW    = N_COLS * ACC_W;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic [N_COLS-1:0] aligned_valid;
    logic [VW-1:0]     aligned_data;
    align_e            align_state;
    logic              push_req;
    logic              fifo_drop;
    logic [CW-1:0]     fifo_count;
    logic              overflow_reg;
    logic              skew_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_COLS; gi++) begin : g_col
            localparam int STAGES = N_COLS - 1 - gi;
            if (STAGES == 0) begin : g_pass
                // Last column is the reference: no delay
                assign aligned_valid[gi]                = bus.col_valid[gi];
                assign aligned_data[gi*ACC_W +: ACC_W]  = bus.col_data[gi*ACC_W +: ACC_W];
            end else begin : g_dly
                logic [STAGES-1:0] v_sr_reg;
                logic [ACC_W-1:0]  d_sr_reg [STAGES];

                // Deskew shift register for this column; flushed by reset or clear
                always_ff @(posedge clk) begin
                    if (!rst_n || clear) begin
                        v_sr_reg <= '0;
                        for (int s = 0; s < STAGES; s++) begin
                            d_sr_reg[s] <= '0;
                        end
                    end else begin
                        v_sr_reg[0] <= bus.col_valid[gi];
                        d_sr_reg[0] <= bus.col_data[gi*ACC_W +: ACC_W];
                        for (int s = 1; s < STAGES; s++) begin
                            v_sr_reg[s] <= v_sr_reg[s-1];
                            d_sr_reg[s] <= d_sr_reg[s-1];
                        end
                    end
                end

                assign aligned_valid[gi]               = v_sr_reg[STAGES-1];
                assign aligned_data[gi*ACC_W +: ACC_W] = d_sr_reg[STAGES-1];
            end
        end
    endgenerate

    // The undelayed last column is still live during clear, so gate it here
    assign align_state = align_classify(&aligned_valid, |aligned_valid);
    assign push_req    = !clear && (align_state == ALIGN_PUSH);

    sa_sync_fifo #(
        .WIDTH (VW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .wr_en    (push_req),
        .wr_data  (aligned_data),
        .rd_en    (bus.out_ready),
        .rd_data  (bus.out_data),
        .rd_valid (bus.out_valid),
        .count    (fifo_count),
        .drop     (fifo_drop)
    );

    // Derived purely from the registered count, so no input-to-output path
    assign bus.almost_full = (fifo_count >= CW'(DEPTH - 1));

    // Sticky error flags, cleared only by reset or clear
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            overflow_reg <= 1'b0;
            skew_err_reg <= 1'b0;
        end else begin
            if (fifo_drop) begin
                overflow_reg <= 1'b1;
            end
            if (align_state == ALIGN_SKEW) begin
                skew_err_reg <= 1'b1;
            end
        end
    end

    assign bus.overflow = overflow_reg;
    assign bus.skew_err = skew_err_reg;

endmodule

// File: tb/tb_sa_output_collector.sv
// Testbench for sa_output_collector: table-driven skewed stimulus, expected
// vectors queued at issue time and compared by an independent output monitor.
module tb_sa_output_collector;
    import sa_pkg::*;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int ACC_W = 32;
    localparam int VW    = N * ACC_W;
    localparam int TLEN  = 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    sa_output_collector_if #(.N_COLS(N), .ACC_W(ACC_W)) bus ();

    sa_output_collector #(
        .DATAWIDTH (DW),
        .N_COLS    (N),
        .DEPTH     (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [VW-1:0] exp_q [$];
    int            pop_cyc_q [$];
    int            valid_hi_cnt = 0;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) valid_hi_cnt++;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            pop_cyc_q.push_back(cyc);
            $display("pop  cyc=%0d data=%h", cyc, bus.out_data);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got %h expected no output", bus.out_data);
            end else begin
                check("out_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    // Stimulus tables indexed by cycle offset within a test
    logic [N-1:0]     ev_v   [TLEN];
    logic [ACC_W-1:0] ev_d   [TLEN][N];
    logic             ev_rdy [TLEN];
    logic             ev_rst [TLEN];
    int               ev_af  [TLEN];
    int               ev_ovf [TLEN];
    int               ev_skw [TLEN];

    task automatic clear_ev(input logic rdy);
        for (int c = 0; c < TLEN; c++) begin
            ev_v[c]   = '0;
            ev_rdy[c] = rdy;
            ev_rst[c] = 1'b0;
            ev_af[c]  = -1;
            ev_ovf[c] = -1;
            ev_skw[c] = -1;
            for (int j = 0; j < N; j++) ev_d[c][j] = '0;
        end
    endtask

    // Schedule one skewed vector; late_col arrives one cycle later than it should
    task automatic add_vec(input int start, input logic [ACC_W-1:0] base,
                           input int late_col, input bit expect_out);
        logic [VW-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) begin
            int c;
            c = start + j + ((j == late_col) ? 1 : 0);
            ev_v[c][j] = 1'b1;
            ev_d[c][j] = base + ACC_W'(j);
            v[j*ACC_W +: ACC_W] = base + ACC_W'(j);
        end
        if (expect_out) exp_q.push_back(v);
        $display("issue start=%0d data=%h late_col=%0d expect=%0d", start, v, late_col, expect_out);
    endtask

    task automatic play(input int len);
        bit in_rst;
        in_rst = 1'b0;
        for (int c = 0; c < len; c++) begin
            if (ev_rst[c]) in_rst = 1'b1;
            rst_n         = !ev_rst[c];
            bus.out_ready = ev_rdy[c];
            for (int j = 0; j < N; j++) begin
                bus.col_valid[j]               = in_rst ? 1'b0 : ev_v[c][j];
                bus.col_data[j*ACC_W +: ACC_W] = in_rst ? '0 : ev_d[c][j];
            end
            @(negedge clk);
            if (ev_af[c] >= 0)  check_int($sformatf("almost_full@%0d", c), int'(bus.almost_full), ev_af[c]);
            if (ev_ovf[c] >= 0) check_int($sformatf("overflow@%0d", c), int'(bus.overflow), ev_ovf[c]);
            if (ev_skw[c] >= 0) check_int($sformatf("skew_err@%0d", c), int'(bus.skew_err), ev_skw[c]);
            @(posedge clk);
            #1;
        end
        bus.col_valid = '0;
        bus.col_data  = '0;
        rst_n         = 1'b1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        check_int("clear_overflow", int'(bus.overflow), 0);
        check_int("clear_skew_err", int'(bus.skew_err), 0);
        check_int("clear_out_valid", int'(bus.out_valid), 0);
        @(posedge clk);
        #1;
    endtask

    int base_hi;

    initial begin
        bus.col_valid = '0;
        bus.col_data  = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_int("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", bus.out_data, '0);
        check_int("rst_almost_full", int'(bus.almost_full), 0);
        check_int("rst_overflow", int'(bus.overflow), 0);
        check_int("rst_skew_err", int'(bus.skew_err), 0);

        // Single vector, column 0 at cycle 10: output only at cycle 14
        while (cyc != 10) begin
            @(posedge clk);
            #1;
        end
        clear_ev(1'b1);
        add_vec(0, 32'h0000_0100, -1, 1'b1);
        pop_cyc_q.delete();
        base_hi = valid_hi_cnt;
        play(10);
        check_int("single_pops", pop_cyc_q.size(), 1);
        if (pop_cyc_q.size() > 0) check_int("single_cycle", pop_cyc_q[0], 14);
        check_int("single_valid_cycles", valid_hi_cnt - base_hi, 1);
        check_int("single_drained", exp_q.size(), 0);

        // Six back-to-back vectors, consecutive outputs
        clear_ev(1'b1);
        for (int k = 0; k < 6; k++) add_vec(k, 32'hF000_0000 + ACC_W'(k << 8), -1, 1'b1);
        ev_ovf[12] = 0;
        pop_cyc_q.delete();
        play(14);
        check_int("b2b_pops", pop_cyc_q.size(), 6);
        if (pop_cyc_q.size() == 6) check_int("b2b_span", pop_cyc_q[5] - pop_cyc_q[0], 5);
        check_int("b2b_drained", exp_q.size(), 0);

        // Backpressure: 4 buffered, 5th dropped, then drain
        clear_ev(1'b0);
        for (int k = 0; k < 5; k++) add_vec(k, 32'h8000_1000 + ACC_W'(k << 4), -1, k < 4);
        for (int c = 10; c < TLEN; c++) ev_rdy[c] = 1'b1;
        ev_af[5]  = 0;
        ev_af[6]  = 1;
        ev_ovf[7] = 0;
        ev_ovf[8] = 1;
        ev_af[16] = 0;
        pop_cyc_q.delete();
        play(18);
        check_int("bp_pops", pop_cyc_q.size(), 4);
        check_int("bp_overflow_sticky", int'(bus.overflow), 1);
        check_int("bp_drained", exp_q.size(), 0);
        do_clear();

        // Skew error: column 2 late, then a clean vector
        clear_ev(1'b1);
        add_vec(0, 32'h0000_5500, 2, 1'b0);
        add_vec(6, 32'h0000_6600, -1, 1'b1);
        ev_skw[3] = 0;
        ev_skw[4] = 1;
        ev_skw[12] = 1;
        pop_cyc_q.delete();
        play(14);
        check_int("skew_pops", pop_cyc_q.size(), 1);
        check_int("skew_drained", exp_q.size(), 0);
        do_clear();

        // Full buffer with a pop on the push cycle
        clear_ev(1'b0);
        for (int k = 0; k < 5; k++) add_vec(k, 32'h7700_0000 + ACC_W'(k), -1, 1'b1);
        ev_rdy[7] = 1'b1;
        for (int c = 12; c < TLEN; c++) ev_rdy[c] = 1'b1;
        ev_af[7]  = 1;
        ev_af[8]  = 1;
        ev_ovf[8] = 0;
        ev_ovf[16] = 0;
        ev_af[17] = 0;
        pop_cyc_q.delete();
        play(20);
        check_int("fullpop_pops", pop_cyc_q.size(), 5);
        if (pop_cyc_q.size() == 5) begin
            check_int("fullpop_first", pop_cyc_q[0], pop_cyc_q[1] - 5);
            check_int("fullpop_last_span", pop_cyc_q[4] - pop_cyc_q[1], 3);
        end
        check_int("fullpop_drained", exp_q.size(), 0);

        // Reset two cycles into a vector: nothing emerges, flags stay clear
        clear_ev(1'b1);
        add_vec(0, 32'h0000_0100, -1, 1'b0);
        ev_rst[2] = 1'b1;
        base_hi = valid_hi_cnt;
        play(12);
        check_int("rst_mid_valid_cycles", valid_hi_cnt - base_hi, 0);
        check_int("rst_mid_overflow", int'(bus.overflow), 0);
        check_int("rst_mid_skew_err", int'(bus.skew_err), 0);
        check_int("rst_mid_almost_full", int'(bus.almost_full), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sa_output_collector.md
SA_OUTPUT_COLLECTOR -- requirements
Module: sa_output_collector

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, PE operand width; accumulator width ACC_W = 4*DATAWIDTH.
REQ-002 SHALL have parameter N_COLS, default 4, number of systolic array columns drained.
REQ-003 SHALL have parameter DEPTH, default 4, output buffer entries (power of two, >= 2).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port clear  input  1  synchronous flush of deskew lines, buffer and sticky flags.
REQ-007 SHALL have port col_valid  input  N_COLS  per-column valid for the bottom-row PE out_D.
REQ-008 SHALL have port col_data  input  N_COLS*ACC_W  per-column out_D; column j occupies bits [j*ACC_W +: ACC_W].
REQ-009 SHALL have port out_valid  output  1  aligned row vector available.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the vector.
REQ-011 SHALL have port out_data  output  N_COLS*ACC_W  aligned row vector, same column packing as col_data.
REQ-012 SHALL have port almost_full  output  1  buffer free entries <= 1; upstream stalls array feed.
REQ-013 SHALL have port overflow  output  1  sticky: aligned vector dropped because buffer full.
REQ-014 SHALL have port skew_err  output  1  sticky: column valids disagreed at alignment point.

Function
REQ-015 SHALL delay column j (data and valid) by N_COLS-1-j register stages; column N_COLS-1 passes with zero delay.
REQ-016 SHALL, for a vector whose column 0 arrives at cycle T and column j at T+j, form the aligned vector at cycle T+N_COLS-1.
REQ-017 SHALL push the aligned vector into the buffer only when all N_COLS delayed valids are 1.
REQ-018 SHALL, when delayed valids are neither all 0 nor all 1, drop the vector and set skew_err.
REQ-019 SHALL present a pushed vector on out_valid/out_data at T+N_COLS when the buffer was empty (latency N_COLS cycles from column 0).
REQ-020 SHALL hold out_data stable while out_valid=1 and out_ready=0; pop occurs on out_valid & out_ready.
REQ-021 SHALL emit vectors in arrival order with no reordering or duplication.
REQ-022 SHALL, on push with buffer full and no pop same cycle, drop the vector, keep contents, and set overflow.
REQ-023 SHALL, on push with buffer full and pop same cycle, accept the push; count unchanged.
REQ-024 SHALL, on push and pop with buffer empty, store the push; out_valid rises next cycle (no combinational bypass).
REQ-025 SHALL wrap read/write pointers modulo DEPTH; count ranges 0..DEPTH.
REQ-026 SHALL drive almost_full = (count >= DEPTH-1), registered from the count.
REQ-027 SHALL pass ACC_W values unmodified (no saturation, no sign handling).
REQ-028 SHALL, on clear=1, behave as reset for all state; clear ignores col_valid that cycle.

Reset
REQ-029 SHALL, on rst_n=0 at clk edge, zero all deskew registers, pointers, count, out_data, overflow, skew_err; out_valid=0, almost_full=0.
REQ-030 SHALL discard vectors partially in the deskew lines when reset asserts mid-operation; no partial vector emitted after release.
REQ-031 SHALL accept col_valid from the first edge after rst_n returns to 1.

Structure
REQ-032 SHALL take DATAWIDTH, ACC_W and N_COLS defaults from shared package sa_pkg, alongside other systolic-array constants.
REQ-033 SHALL instantiate the buffer as sub-module sa_sync_fifo (width N_COLS*ACC_W, depth DEPTH, count output).
REQ-034 SHALL implement deskew lines as generate-loop shift registers inside sa_output_collector.

Verification (N_COLS=4, DEPTH=4, DATAWIDTH=8)
REQ-035 SHALL test single vector: col j valid at cycle 10+j with data 0x100+j, out_ready=1 -> out_valid=1 only at cycle 14, out_data = {0x103,0x102,0x101,0x100}.
REQ-036 SHALL test back-to-back: 6 skewed vectors on consecutive cycles, out_ready=1 -> 6 outputs on consecutive cycles in order, overflow=0.
REQ-037 SHALL test backpressure: out_ready=0, 5 vectors -> first 4 buffered, almost_full=1 after 3rd, 5th dropped, overflow=1; out_ready=1 then yields vectors 1-4.
REQ-038 SHALL test skew error: column 2 valid one cycle late -> skew_err=1, no vector emitted for it; next correct vector emitted normally.
REQ-039 SHALL test full + simultaneous pop: buffer full, out_ready=1 on push cycle -> push accepted, overflow stays 0, count stays 4.
REQ-040 SHALL test reset mid-operation: rst_n=0 at cycle 12 of REQ-035 stimulus -> no out_valid afterward, all flags 0.
